retire_rat_flash: RTL
=====================

Name: retire_rat_flash

Overview:
Parametrised committed-state register alias table: one INT bank and one FP bank, each ARCH_REGS entries.
- Accepts up to RETIRE_W retiring mappings per cycle.
- Returns displaced physical registers to the free list one cycle later, registered.
- On a flush request, streams the committed map to the speculative RAT over FLASH_LANES-wide beats under a busy/done handshake, instead of a flat wide bus.
- Sits between the retire unit, the free list and the speculative RAT.

Parameters:
RETIRE_W, 4, retire lanes per cycle
ARCH_REGS, 32, architectural registers per bank (power of 2)
INT_PRF_DEPTH, 64, INT physical registers
FP_PRF_DEPTH, 64, FP physical registers
FLASH_LANES, 8, entries per bank per flash beat; divides ARCH_REGS
Derived: AW=$clog2(ARCH_REGS), IPL=$clog2(INT_PRF_DEPTH), FPL=$clog2(FP_PRF_DEPTH), PML=max(IPL,FPL), NBEAT=ARCH_REGS/FLASH_LANES

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ret_valid  in  RETIRE_W  per-lane retire valid
ret_isfp  in  RETIRE_W  1=FP destination
ret_rd  in  RETIRE_W*AW  architectural destination
ret_prd  in  RETIRE_W*PML  new physical mapping
ret_ready  out  1  retire accepted this cycle
free_valid  out  RETIRE_W  free-list write enable
free_isfp  out  RETIRE_W  type of freed register
free_prd  out  RETIRE_W*PML  freed physical register, zero-extended
flash_req  in  1  one-cycle flush request
flash_busy  out  1  flash in progress
flash_valid  out  1  beat valid
flash_beat  out  $clog2(NBEAT)+1  beat index
flash_int  out  FLASH_LANES*IPL  INT mappings, entry 0 lowest
flash_fp  out  FLASH_LANES*FPL  FP mappings
flash_done  out  1  one-cycle pulse after last beat
int_map_bits  out  INT_PRF_DEPTH  registered; bit i=1 ⇒ INT preg i mapped by arch 1..ARCH_REGS-1
fp_map_bits  out  FP_PRF_DEPTH  registered; bit i=1 ⇒ FP preg i mapped

Behaviour:
- Async reset (rst_n low), effective immediately, including mid-flash:
  - INT[r]=r and FP[r]=r.
  - State=IDLE, beat counter=0.
  - All outputs 0, except ret_ready=1 once rst_n is high.
  - int_map_bits = bits 1..ARCH_REGS-1 set; fp_map_bits = bits 0..ARCH_REGS-1 set.
- Retire acceptance: lane accepted when ret_valid & ret_ready.
- INT rd=0: never written, never freed; free_valid=0 for that lane.
- Table write at posedge. When several lanes hit the same (type,rd), the highest lane index wins.
- Free output, registered, 1-cycle latency:
  - free_valid[k]=accepted[k] (excluding INT x0).
  - free_prd[k]=pre-update table value, overridden by the highest lower lane j<k with the same type and rd: ret_prd[j].
  - Zero-extended to PML.
- Map bits: recomputed from the post-update table and registered in the same edge as the table write.
- FSM IDLE/FLASH/DONE:
  - IDLE→FLASH on flash_req.
  - Retire in the same cycle as flash_req is still accepted; flash reads the post-update table.
  - FLASH: ret_ready=0, flash_busy=1, flash_valid=1.
  - Beat b drives entries b*FLASH_LANES..+FLASH_LANES-1 from both banks. One beat per cycle, no backpressure; b counts 0..NBEAT-1.
  - After beat NBEAT-1 → DONE.
  - DONE: flash_done=1 and flash_busy=1 for one cycle, then IDLE with ret_ready=1.
  - flash_req in FLASH/DONE: ignored.
  - Total flash latency = NBEAT+1 cycles from the cycle after the request.
- free_valid never asserts in FLASH/DONE except from a retire accepted in the request cycle, which asserts in FLASH beat 0.
- ret_ready is combinational from state only.

Decomposition:
- Shared package/defines: REG_TYPE_INT/FP encodings; derived widths IPL, FPL, PML; FSM state encoding.
- Natural sub-module: rat_bank (ARCH_REGS×width array)
  - RETIRE_W prioritised write ports.
  - RETIRE_W combinational read ports with same-cycle lower-lane forwarding.
  - One FLASH_LANES-wide beat read port.
  - Instantiated twice: INT and FP.

Test Plan:
1. Reset then idle: INT[5]=5; int_map_bits[0]=0, bits[31:1]=1; fp_map_bits[31:0]=1; ret_ready=1; free_valid=0.
2. Chained rename, 4 lanes INT rd=4 prd=40,41,42,43: next cycle free_prd={42,41,40,4}, all free_valid=1; later INT[4]=43; int_map_bits[43]=1, bit 4=0.
3. Mixed types, lane0 INT rd3→50, lane1 FP rd3→60, lane2 INT rd0→55: free_prd lane0=3, lane1=3; lane2 free_valid=0; INT[0] stays 0.
4. flash_req with lane0 INT rd7→33 in the same cycle, FLASH_LANES=8: flash_busy next cycle; 4 beats; beat0 flash_int entry7=33; flash_done pulses at cycle 5; ret_ready=0 for exactly 5 cycles.
5. flash_req repeated during FLASH and ret_valid held high: no restart, no acceptance, no free_valid; single flash_done.
6. rst_n asserted at beat 2: flash_busy=0 and flash_valid=0 immediately; table identity; ret_ready=1 after release.

Source files
------------

// File: rtl/retire_rat_flash_pkg.sv
// Shared encodings and width helper for the committed-state RAT.
// No logic of its own; imported by the bank and the top.
package retire_rat_flash_pkg;

  localparam logic REG_TYPE_INT = 1'b0;
  localparam logic REG_TYPE_FP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_DONE  = 2'd2
  } flash_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/retire_rat_flash_bank.sv
// One committed map bank: prioritised retire writes, forwarded old-value reads, beat read, map bits.
// Writes and map bits take effect at the clock edge; reads are combinational; no backpressure.
module retire_rat_flash_bank
  import retire_rat_flash_pkg::*;
#(
  parameter int ARCH_REGS   = 32,
  parameter int W           = 6,
  parameter int DEPTH       = 64,
  parameter int RETIRE_W    = 4,
  parameter int FLASH_LANES = 8,
  parameter int BW          = 3,
  parameter bit SKIP_ZERO   = 1'b0,
  localparam int AW         = $clog2(ARCH_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RETIRE_W-1:0]       wr_en,
  input  logic [RETIRE_W*AW-1:0]    wr_rd,
  input  logic [RETIRE_W*W-1:0]     wr_dat,
  output logic [RETIRE_W*W-1:0]     rd_dat,
  input  logic [BW-1:0]             beat_idx,
  output logic [FLASH_LANES*W-1:0]  beat_dat,
  output logic [DEPTH-1:0]          map_bits
);

  logic [W-1:0]     tbl_q [ARCH_REGS];
  logic [W-1:0]     tbl_d [ARCH_REGS];
  logic [DEPTH-1:0] map_d;

  // Later lanes overwrite earlier ones, so the highest lane wins on a shared rd.
  always_comb begin
    tbl_d = tbl_q;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (wr_en[k]) tbl_d[wr_rd[k*AW +: AW]] = wr_dat[k*W +: W];
    end
    map_d = '0;
    for (int r = 0; r < ARCH_REGS; r++) begin
      if (!(SKIP_ZERO && r == 0)) map_d[tbl_d[r]] = 1'b1;
    end
  end

  // Old value seen by lane k includes any lower lane renaming the same rd this cycle.
  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      rd_dat[k*W +: W] = tbl_q[wr_rd[k*AW +: AW]];
      for (int j = 0; j < RETIRE_W; j++) begin
        if (j < k && wr_en[j] && wr_rd[j*AW +: AW] == wr_rd[k*AW +: AW])
          rd_dat[k*W +: W] = wr_dat[j*W +: W];
      end
    end
  end

  for (genvar l = 0; l < FLASH_LANES; l++) begin : g_beat
    assign beat_dat[l*W +: W] = tbl_q[AW'(int'(beat_idx) * FLASH_LANES + l)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ARCH_REGS; r++) tbl_q[r] <= W'(r);
      for (int i = 0; i < DEPTH; i++)
        map_bits[i] <= (i < ARCH_REGS) && !(SKIP_ZERO && i == 0);
    end else begin
      tbl_q    <= tbl_d;
      map_bits <= map_d;
    end
  end

endmodule

// File: rtl/retire_rat_flash.sv
// Committed INT/FP RAT: retires up to RETIRE_W mappings, frees old pregs, flashes the map on flush.
// Free output one cycle after retire; flash is NBEAT beats plus a done cycle; retire stalls while flashing.
module retire_rat_flash
  import retire_rat_flash_pkg::*;
#(
  parameter int RETIRE_W      = 4,
  parameter int ARCH_REGS     = 32,
  parameter int INT_PRF_DEPTH = 64,
  parameter int FP_PRF_DEPTH  = 64,
  parameter int FLASH_LANES   = 8,
  localparam int AW    = $clog2(ARCH_REGS),
  localparam int IPL   = $clog2(INT_PRF_DEPTH),
  localparam int FPL   = $clog2(FP_PRF_DEPTH),
  localparam int PML   = max_w(IPL, FPL),
  localparam int NBEAT = ARCH_REGS / FLASH_LANES,
  localparam int BW    = $clog2(NBEAT) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RETIRE_W-1:0]        ret_valid,
  input  logic [RETIRE_W-1:0]        ret_isfp,
  input  logic [RETIRE_W*AW-1:0]     ret_rd,
  input  logic [RETIRE_W*PML-1:0]    ret_prd,
  output logic                       ret_ready,
  output logic [RETIRE_W-1:0]        free_valid,
  output logic [RETIRE_W-1:0]        free_isfp,
  output logic [RETIRE_W*PML-1:0]    free_prd,
  input  logic                       flash_req,
  output logic                       flash_busy,
  output logic                       flash_valid,
  output logic [BW-1:0]              flash_beat,
  output logic [FLASH_LANES*IPL-1:0] flash_int,
  output logic [FLASH_LANES*FPL-1:0] flash_fp,
  output logic                       flash_done,
  output logic [INT_PRF_DEPTH-1:0]   int_map_bits,
  output logic [FP_PRF_DEPTH-1:0]    fp_map_bits
);

  flash_state_e state_q;
  logic [BW-1:0] beat_q;

  logic [RETIRE_W-1:0]        int_wen, fp_wen;
  logic [RETIRE_W*IPL-1:0]    int_wdat, int_old;
  logic [RETIRE_W*FPL-1:0]    fp_wdat, fp_old;
  logic [FLASH_LANES*IPL-1:0] int_beat;
  logic [FLASH_LANES*FPL-1:0] fp_beat;
  logic [RETIRE_W*PML-1:0]    free_prd_d;

  assign ret_ready = (state_q == ST_IDLE);

  // INT x0 is hardwired: never renamed, never freed.
  for (genvar k = 0; k < RETIRE_W; k++) begin : g_lane
    assign int_wen[k] = ret_valid[k] && ret_ready && (ret_isfp[k] == REG_TYPE_INT)
                        && (ret_rd[k*AW +: AW] != '0);
    assign fp_wen[k]  = ret_valid[k] && ret_ready && (ret_isfp[k] == REG_TYPE_FP);
    assign int_wdat[k*IPL +: IPL] = ret_prd[k*PML +: IPL];
    assign fp_wdat[k*FPL +: FPL]  = ret_prd[k*PML +: FPL];
    assign free_prd_d[k*PML +: PML] =
        fp_wen[k]  ? PML'(fp_old[k*FPL +: FPL]) :
        int_wen[k] ? PML'(int_old[k*IPL +: IPL]) : '0;
  end

  retire_rat_flash_bank #(
    .ARCH_REGS(ARCH_REGS), .W(IPL), .DEPTH(INT_PRF_DEPTH), .RETIRE_W(RETIRE_W),
    .FLASH_LANES(FLASH_LANES), .BW(BW), .SKIP_ZERO(1'b1)
  ) u_int_bank (
    .clk(clk), .rst_n(rst_n),
    .wr_en(int_wen), .wr_rd(ret_rd), .wr_dat(int_wdat), .rd_dat(int_old),
    .beat_idx(beat_q), .beat_dat(int_beat), .map_bits(int_map_bits)
  );

  retire_rat_flash_bank #(
    .ARCH_REGS(ARCH_REGS), .W(FPL), .DEPTH(FP_PRF_DEPTH), .RETIRE_W(RETIRE_W),
    .FLASH_LANES(FLASH_LANES), .BW(BW), .SKIP_ZERO(1'b0)
  ) u_fp_bank (
    .clk(clk), .rst_n(rst_n),
    .wr_en(fp_wen), .wr_rd(ret_rd), .wr_dat(fp_wdat), .rd_dat(fp_old),
    .beat_idx(beat_q), .beat_dat(fp_beat), .map_bits(fp_map_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid <= '0;
      free_isfp  <= '0;
      free_prd   <= '0;
    end else begin
      free_valid <= int_wen | fp_wen;
      free_isfp  <= fp_wen;
      free_prd   <= free_prd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      flash_busy  <= 1'b0;
      flash_valid <= 1'b0;
      flash_done  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (flash_req) begin
          state_q     <= ST_FLASH;
          beat_q      <= '0;
          flash_busy  <= 1'b1;
          flash_valid <= 1'b1;
        end
        ST_FLASH: begin
          if (beat_q == BW'(NBEAT - 1)) begin
            state_q     <= ST_DONE;
            beat_q      <= '0;
            flash_valid <= 1'b0;
            flash_done  <= 1'b1;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          flash_busy <= 1'b0;
          flash_done <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          beat_q      <= '0;
          flash_busy  <= 1'b0;
          flash_valid <= 1'b0;
          flash_done  <= 1'b0;
        end
      endcase
    end
  end

  assign flash_beat = beat_q;
  assign flash_int  = flash_valid ? int_beat : '0;
  assign flash_fp   = flash_valid ? fp_beat  : '0;

endmodule
